food_placer: RTL
================

Name: food_placer

Overview:
Upstream stage of the game-logic core. Produces the coordinates of the next food cell on request.
- Draws a pseudo-random candidate cell from a free-running LFSR.
- Probes the block grid through a read port to check the cell.
- If the cell is occupied, scans forward in raster order to the nearest empty cell.
- Returns the coordinates with a valid/accept handshake, or flags that the grid is full.

Parameters:
GRID_WIDTH, 80, grid columns (H range 0..GRID_WIDTH-1); 1..256
GRID_HEIGHT, 60, grid rows (V range 0..GRID_HEIGHT-1); 1..256
BITS_PER_BLOCK, 2, width of one grid cell code
BLOCK_EMPTY, 0, cell code meaning empty
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
Clock  in  1  single clock domain; rising edge
ResetN  in  1  asynchronous, active-low reset
Request  in  1  one-cycle pulse: start finding a food cell
Entropy  in  1  raw button activity, mixed into the LFSR
RdV  out  VW=$clog2(GRID_HEIGHT)  grid read row
RdH  out  HW=$clog2(GRID_WIDTH)  grid read column
RdBlock  in  BITS_PER_BLOCK  cell code for the RdV/RdH presented last cycle (1-cycle synchronous read)
FoodV  out  VW  chosen row
FoodH  out  HW  chosen column
FoodValid  out  1  FoodV/FoodH hold a result
FoodAccept  in  1  consumer takes the result
GridFull  out  1  no empty cell exists
Busy  out  1  search in progress

Behaviour:
Reset (ResetN low, asynchronous):
- LFSR = SEED; state = IDLE.
- FoodV, FoodH, RdV, RdH = 0; FoodValid, GridFull, Busy = 0.

LFSR:
- 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
- Steps every cycle out of reset, in every state.
- Feedback bit is XORed with Entropy.
- If the next value would be 0, load SEED instead.

States:
- IDLE:
  - Request=1 and FoodValid=0 -> DRAW; clear GridFull; Busy=1.
  - Request while FoodValid=1 is ignored.
- DRAW (1 cycle per attempt):
  - candV = lfsr[VW-1:0]; candH = lfsr[8+HW-1:8].
  - If candV>=GRID_HEIGHT or candH>=GRID_WIDTH, reject and stay in DRAW with the next LFSR value.
  - Otherwise RdV/RdH = cand, probe count = 0 -> WAIT.
- WAIT (1 cycle): read latency; -> CHECK.
- CHECK:
  - RdBlock==BLOCK_EMPTY: FoodV/FoodH = RdV/RdH; FoodValid=1; Busy=0 -> IDLE.
  - Else increment probe count.
    - If count == GRID_WIDTH*GRID_HEIGHT: GridFull=1; Busy=0 -> IDLE.
    - Otherwise advance one cell in raster order -> WAIT:
      - RdH+1.
      - At RdH==GRID_WIDTH-1: RdH=0 and RdV+1.
      - At last cell: wrap to (0,0).

Timing:
- Empty candidate: FoodValid rises 3 cycles after the first accepted DRAW cycle.
- Each additional probe adds 2 cycles.
- Probe counter width: $clog2(GRID_WIDTH*GRID_HEIGHT+1).

Handshake:
- FoodValid and FoodV/FoodH hold stable until a cycle with FoodAccept=1; FoodValid clears on the next edge.
- FoodAccept while FoodValid=0 is ignored.
- Request and FoodAccept in the same cycle with FoodValid=1: the accept completes, the request is dropped.

Boundaries:
- Request while Busy: ignored.
- GridFull holds until the next accepted Request.
- RdV/RdH hold their last value while IDLE.
- Reset asserted mid-search aborts immediately; no partial result is presented.

Test Plan:
1. Grid model all BLOCK_EMPTY, SEED=16'hACE1, Entropy=0; Request at cycle 5 -> FoodValid within 3 cycles of the first in-range draw; FoodV<60, FoodH<80; coordinates match a bit-exact LFSR reference model.
2. Model marks the first accepted candidate (v,h) and its next 4 raster cells non-empty -> result = candidate+5 in raster order; FoodValid 3+2*5=13 cycles after the accepted draw.
3. Candidate (59,79) occupied, (0,0) empty -> raster wrap; result (0,0).
4. All 4800 cells non-empty -> after 4800 probes GridFull=1, FoodValid=0, Busy=0; a new Request clears GridFull.
5. Result presented, FoodAccept held 0 for 20 cycles with Requests pulsed -> FoodV/FoodH stable, no new search; FoodAccept=1 -> FoodValid=0 next cycle.
6. ResetN pulled low during WAIT -> all outputs 0 asynchronously; LFSR=16'hACE1 on release; a subsequent Request completes normally.

Source files
------------

// File: rtl/food_placer.sv
// food_placer: picks the coordinates of the next food cell on request.
// A free-running 16-bit LFSR proposes a candidate cell. The grid is probed
// through a 1-cycle synchronous read port. If the cell is occupied, the
// search walks forward in raster order until it finds an empty cell. If no
// empty cell exists, it reports that the grid is full.
//
// State table:
//   S_IDLE  | waiting for a request; a pending result is held here
//   S_DRAW  | take a candidate from the LFSR, redraw while out of range
//   S_WAIT  | read latency of the grid port
//   S_CHECK | examine the returned cell; finish or advance one cell
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_request            one-cycle pulse that starts a search
//   i_entropy            raw button activity, mixed into the LFSR feedback
//   o_rd_v, o_rd_h       grid read address
//   i_rd_block           cell code for the address presented last cycle
//   o_food_v, o_food_h   chosen cell
//   o_food_valid         result is present; held until i_food_accept
//   i_food_accept        consumer takes the result
//   o_grid_full          the last search found no empty cell
//   o_busy               search in progress
module food_placer #(
  parameter int GRID_WIDTH     = 80,
  parameter int GRID_HEIGHT    = 60,
  parameter int BITS_PER_BLOCK = 2,
  parameter logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY = '0,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int VW = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1,
  localparam int HW = (GRID_WIDTH  > 1) ? $clog2(GRID_WIDTH)  : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_request,
  input  logic                      i_entropy,
  output logic [VW-1:0]             o_rd_v,
  output logic [HW-1:0]             o_rd_h,
  input  logic [BITS_PER_BLOCK-1:0] i_rd_block,
  output logic [VW-1:0]             o_food_v,
  output logic [HW-1:0]             o_food_h,
  output logic                      o_food_valid,
  input  logic                      i_food_accept,
  output logic                      o_grid_full,
  output logic                      o_busy
);

  localparam int CELLS = GRID_WIDTH * GRID_HEIGHT;
  localparam int CW    = $clog2(CELLS + 1);

  localparam logic [CW-1:0] LAST_PROBE = CW'(CELLS);
  localparam logic [VW-1:0] V_MAX      = VW'(GRID_HEIGHT - 1);
  localparam logic [HW-1:0] H_MAX      = HW'(GRID_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic [VW-1:0]   r_rd_v;
  logic [HW-1:0]   r_rd_h;
  logic [VW-1:0]   r_food_v;
  logic [HW-1:0]   r_food_h;
  logic            r_food_valid;
  logic            r_grid_full;
  logic [CW-1:0]   r_probe_cnt;

  state_t          w_state_nxt;
  logic [15:0]     w_lfsr_nxt;
  logic [VW-1:0]   w_rd_v_nxt;
  logic [HW-1:0]   w_rd_h_nxt;
  logic [VW-1:0]   w_food_v_nxt;
  logic [HW-1:0]   w_food_h_nxt;
  logic            w_food_valid_nxt;
  logic            w_grid_full_nxt;
  logic [CW-1:0]   w_probe_cnt_nxt;

  logic            w_lfsr_fb;
  logic [15:0]     w_lfsr_shift;
  logic [VW-1:0]   w_cand_v;
  logic [HW-1:0]   w_cand_h;
  logic            w_cand_ok;
  logic [VW-1:0]   w_adv_v;
  logic [HW-1:0]   w_adv_h;
  logic [CW-1:0]   w_probe_inc;

  // x^16+x^14+x^13+x^11+1, shifting left; the all-zero lock-up state is
  // escaped by reloading the seed (entropy could otherwise force it).
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10] ^ i_entropy;
  assign w_lfsr_shift = {r_lfsr[14:0], w_lfsr_fb};
  assign w_lfsr_nxt   = (w_lfsr_shift == 16'h0000) ? SEED : w_lfsr_shift;

  // Row from the low byte and column from the high byte, so the two
  // coordinates are not taken from overlapping bits.
  assign w_cand_v  = r_lfsr[VW-1:0];
  assign w_cand_h  = r_lfsr[8 +: HW];
  assign w_cand_ok = (w_cand_v <= V_MAX) && (w_cand_h <= H_MAX);

  // Next cell in raster order, wrapping from the last cell to (0,0).
  always_comb begin
    w_adv_v = r_rd_v;
    w_adv_h = r_rd_h + 1'b1;
    if (r_rd_h == H_MAX) begin
      w_adv_h = '0;
      w_adv_v = (r_rd_v == V_MAX) ? '0 : r_rd_v + 1'b1;
    end
  end

  assign w_probe_inc = r_probe_cnt + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_rd_v_nxt       = r_rd_v;
    w_rd_h_nxt       = r_rd_h;
    w_food_v_nxt     = r_food_v;
    w_food_h_nxt     = r_food_h;
    w_food_valid_nxt = r_food_valid;
    w_grid_full_nxt  = r_grid_full;
    w_probe_cnt_nxt  = r_probe_cnt;

    case (r_state)
      S_IDLE: begin
        // An accept completes even if a request arrives in the same cycle;
        // that request is dropped because a result is still pending.
        if (r_food_valid) begin
          if (i_food_accept) w_food_valid_nxt = 1'b0;
        end else if (i_request) begin
          w_grid_full_nxt = 1'b0;
          w_state_nxt     = S_DRAW;
        end
      end
      S_DRAW: begin
        if (w_cand_ok) begin
          w_rd_v_nxt      = w_cand_v;
          w_rd_h_nxt      = w_cand_h;
          w_probe_cnt_nxt = '0;
          w_state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (i_rd_block == BLOCK_EMPTY) begin
          w_food_v_nxt     = r_rd_v;
          w_food_h_nxt     = r_rd_h;
          w_food_valid_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else begin
          w_probe_cnt_nxt = w_probe_inc;
          if (w_probe_inc == LAST_PROBE) begin
            w_grid_full_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_rd_v_nxt  = w_adv_v;
            w_rd_h_nxt  = w_adv_h;
            w_state_nxt = S_WAIT;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_lfsr       <= SEED;
      r_rd_v       <= '0;
      r_rd_h       <= '0;
      r_food_v     <= '0;
      r_food_h     <= '0;
      r_food_valid <= 1'b0;
      r_grid_full  <= 1'b0;
      r_probe_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_rd_v       <= w_rd_v_nxt;
      r_rd_h       <= w_rd_h_nxt;
      r_food_v     <= w_food_v_nxt;
      r_food_h     <= w_food_h_nxt;
      r_food_valid <= w_food_valid_nxt;
      r_grid_full  <= w_grid_full_nxt;
      r_probe_cnt  <= w_probe_cnt_nxt;
    end
  end

  assign o_rd_v       = r_rd_v;
  assign o_rd_h       = r_rd_h;
  assign o_food_v     = r_food_v;
  assign o_food_h     = r_food_h;
  assign o_food_valid = r_food_valid;
  assign o_grid_full  = r_grid_full;
  assign o_busy       = (r_state != S_IDLE);

endmodule
